// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter: round-robin owner of a shared register's load/clear/in controls.
// Optional `ARB_LOCK_EN: lock[] lets the granted requester keep the grant for up to 4 ops.
//
//   state | meaning
//   IDLE  | waiting; clr_req beats req[], otherwise round-robin grant
//   LOAD  | reg_load high, reg_in driven with the granted requester's data
//   CLR   | reg_clear high
//   DONE  | ack / clr_ack pulse, round-robin pointer update
module reg_load_arbiter #(
  parameter  int N    = 8,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_data,
  input  logic              clr_req,
  input  logic [NREQ-1:0]   lock,
  output logic              reg_load,
  output logic              reg_clear,
  output logic [N-1:0]      reg_in,
  output logic [NREQ-1:0]   ack,
  output logic              clr_ack,
  output logic [IDW-1:0]    grant_id,
  output logic              busy
);

`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam logic [2:0] LOCK_MAX = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CLR  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [IDW-1:0]    rr_ptr, rr_nxt;
  logic [IDW-1:0]    grant_nxt;
  logic              load_nxt, clear_nxt, clr_ack_nxt;
  logic [N-1:0]      in_nxt;
  logic [NREQ-1:0]   ack_nxt;
  logic              lock_hold, hold_nxt;
  logic [2:0]        lock_cnt, cnt_nxt;

  logic              rr_found;
  logic [IDW-1:0]    rr_pick;
  logic              take_hold;
  logic [IDW-1:0]    pick;
  logic [IDW-1:0]    ptr_after;

  // First requesting index at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    logic [IDW-1:0] idx_v;
    idx      = 0;
    idx_v    = '0;
    rr_found = 1'b0;
    rr_pick  = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_v = IDW'(idx);
      if (!rr_found && req[idx_v]) begin
        rr_found = 1'b1;
        rr_pick  = idx_v;
      end
    end
  end

  assign take_hold = lock_hold && req[grant_id];
  assign pick      = take_hold ? grant_id : rr_pick;
  assign ptr_after = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    grant_nxt   = grant_id;
    load_nxt    = 1'b0;
    clear_nxt   = 1'b0;
    in_nxt      = reg_in;
    ack_nxt     = '0;
    clr_ack_nxt = 1'b0;
    hold_nxt    = lock_hold;
    cnt_nxt     = lock_cnt;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLR;
          clear_nxt = 1'b1;
        end else if (take_hold || rr_found) begin
          state_nxt = LOAD;
          load_nxt  = 1'b1;
          grant_nxt = pick;
          in_nxt    = req_data[pick*N +: N];
          hold_nxt  = 1'b0;
          cnt_nxt   = take_hold ? lock_cnt + 3'd1 : 3'd1;
        end
      end
      LOAD: begin
        state_nxt = DONE;
        ack_nxt   = NREQ'(1) << grant_id;
      end
      CLR: begin
        state_nxt   = DONE;
        clr_ack_nxt = 1'b1;
      end
      DONE: begin
        state_nxt = IDLE;
        // ack is still high here only when the finishing op was a load.
        if (|ack) begin
          if (LOCK_EN && lock[grant_id] && req[grant_id] && (lock_cnt < LOCK_MAX)) begin
            hold_nxt = 1'b1;
          end else begin
            hold_nxt = 1'b0;
            rr_nxt   = ptr_after;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      reg_load  <= 1'b0;
      reg_clear <= 1'b0;
      reg_in    <= '0;
      ack       <= '0;
      clr_ack   <= 1'b0;
      busy      <= 1'b0;
      lock_hold <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      rr_ptr    <= rr_nxt;
      grant_id  <= grant_nxt;
      reg_load  <= load_nxt;
      reg_clear <= clear_nxt;
      reg_in    <= in_nxt;
      ack       <= ack_nxt;
      clr_ack   <= clr_ack_nxt;
      busy      <= (state_nxt != IDLE);
      lock_hold <= hold_nxt;
      lock_cnt  <= cnt_nxt;
    end
  end

endmodule
